// File: rtl/vector_serializer.sv
// vector_serializer: buffers up to DEPTH N-channel result vectors and streams
// them out one WORD_SIZE word per cycle, with sign or zero extension.
// The `last` tag is stored per slot and raised on the final word of its vector.
// Optional build macro: VSER_HEADER_EN. When defined, every vector is preceded
// by a header word carrying a marker bit, the slot last flag and a 16-bit
// sequence number.
module vector_serializer #(
  parameter int N           = 10,
  parameter int DATA_BITS   = 18,
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH       = 2,
  parameter int SIGN_EXTEND = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [DATA_BITS-1:0] in_data [N],
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        upstream_stall,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic                        out_valid,
  output logic                        out_last,
  input  logic                        downstream_stall
);

`ifdef VSER_HEADER_EN
  // Word index 0 is the header, 1..N are the channel values.
  localparam int LAST_IDX = N;
`else
  localparam int LAST_IDX = N - 1;
`endif
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = (LAST_IDX > 0) ? $clog2(LAST_IDX + 1) : 1;
  localparam int DIDX_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
`ifdef VSER_HEADER_EN
  logic [15:0]      seq_q, seq_d;
  logic [WORD_SIZE-1:0] hdr_word;
`endif

  logic                 accept;
  logic                 xfer;
  logic                 vec_done;
  logic [DIDX_W-1:0]    data_idx;
  logic [DATA_BITS-1:0] cur_val;
  logic [WORD_SIZE-1:0] ext_word;
  logic [DATA_BITS-1:0] chan_val [N];
  logic                 slot_last_mem [DEPTH];

  // Stall and valid depend only on the registered occupancy, never on inputs.
  assign upstream_stall = (count_q == CNT_W'(DEPTH));
  assign out_valid      = (count_q != '0);

  // One small memory per channel; the read side is a mux on rd_ptr.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    logic [DATA_BITS-1:0] chan_mem [DEPTH];

    // Capture this channel's value into the write slot on accept.
    always_ff @(posedge clock) begin
      if (!reset && accept) begin
        chan_mem[wr_ptr_q] <= in_data[gi];
      end
    end

    assign chan_val[gi] = chan_mem[rd_ptr_q];
  end

  // Capture the per-vector last tag alongside its data.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      slot_last_mem[wr_ptr_q] <= in_last;
    end
  end

  // Extension of the selected channel value to a full output word.
  if (DATA_BITS == WORD_SIZE) begin : g_pass
    assign ext_word = cur_val;
  end else begin : g_ext
    logic fill_bit;
    assign fill_bit = (SIGN_EXTEND != 0) ? cur_val[DATA_BITS-1] : 1'b0;
    assign ext_word = {{(WORD_SIZE - DATA_BITS){fill_bit}}, cur_val};
  end

  // Next-state: pointer wrap, occupancy and word position within a vector.
  always_comb begin
    accept   = in_valid && !upstream_stall;
    xfer     = out_valid && !downstream_stall;
    vec_done = xfer && (word_idx_q == IDX_W'(LAST_IDX));

    wr_ptr_d = wr_ptr_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end

    rd_ptr_d = rd_ptr_q;
    if (vec_done) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    count_d = count_q;
    if (accept && !vec_done) begin
      count_d = count_q + 1'b1;
    end else if (!accept && vec_done) begin
      count_d = count_q - 1'b1;
    end

    word_idx_d = word_idx_q;
    if (vec_done) begin
      word_idx_d = '0;
    end else if (xfer) begin
      word_idx_d = word_idx_q + 1'b1;
    end

`ifdef VSER_HEADER_EN
    seq_d = vec_done ? seq_q + 16'd1 : seq_q;
`endif
  end

  // State registers; slot contents are deliberately left untouched by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
`ifdef VSER_HEADER_EN
      seq_q      <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
`ifdef VSER_HEADER_EN
      seq_q      <= seq_d;
`endif
    end
  end

  // Output mux: select the current word of the head slot from registers.
  always_comb begin
`ifdef VSER_HEADER_EN
    data_idx = (word_idx_q == '0) ? '0 : DIDX_W'(word_idx_q - 1'b1);
    hdr_word = '0;
    hdr_word[WORD_SIZE-1] = 1'b1;
    hdr_word[WORD_SIZE-2] = slot_last_mem[rd_ptr_q];
    hdr_word[15:0]        = seq_q;
`else
    data_idx = DIDX_W'(word_idx_q);
`endif
    cur_val  = chan_val[data_idx];
    out_data = ext_word;
`ifdef VSER_HEADER_EN
    if (word_idx_q == '0) begin
      out_data = hdr_word;
    end
`endif
    out_last = out_valid && slot_last_mem[rd_ptr_q] &&
               (word_idx_q == IDX_W'(LAST_IDX));
  end

endmodule

// File: tb/tb_vector_serializer.sv
// Testbench for vector_serializer: two instances (N=10/DEPTH=2/sign-extend and
// N=1/DEPTH=3/zero-extend) checked by a queue-based scoreboard.
module tb_vector_serializer;

  localparam int A_N = 10;
  localparam int A_DEPTH = 2;
  localparam int B_N = 1;
  localparam int B_DEPTH = 3;

  typedef struct {
    logic [31:0] data;
    logic        last;
    bit          eov;
  } exp_t;

  logic clk;
  logic reset;

  logic signed [17:0] a_data [A_N];
  logic        a_valid, a_last, a_ustall, a_ovalid, a_olast, a_dstall;
  logic [31:0] a_odata;

  logic signed [17:0] b_data [B_N];
  logic        b_valid, b_last, b_ustall, b_ovalid, b_olast, b_dstall;
  logic [31:0] b_odata;

  logic signed [17:0] b_vals [10];

  exp_t exp_q [2][$];
  int   vec_cnt [2];
  int   seq_num [2];
  int   n_tests = 0;
  int   n_fail = 0;

  vector_serializer #(.N(A_N), .DATA_BITS(18), .WORD_SIZE(32), .DEPTH(A_DEPTH), .SIGN_EXTEND(1)) dut_a (
    .clock(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
    .upstream_stall(a_ustall), .out_data(a_odata), .out_valid(a_ovalid), .out_last(a_olast),
    .downstream_stall(a_dstall)
  );

  vector_serializer #(.N(B_N), .DATA_BITS(18), .WORD_SIZE(32), .DEPTH(B_DEPTH), .SIGN_EXTEND(0)) dut_b (
    .clock(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
    .upstream_stall(b_ustall), .out_data(b_odata), .out_valid(b_ovalid), .out_last(b_olast),
    .downstream_stall(b_dstall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension: interpret the 18-bit value as a number, widen to 32 bits.
  function automatic logic [31:0] extend(input logic signed [17:0] v, input bit se);
    int sv;
    sv = int'(v);
    if (!se && sv < 0) sv = sv + 262144;
    return 32'(sv);
  endfunction

  // Queue the words a freshly accepted vector must produce.
  task automatic push_vec(input int id, input int n, input bit se,
                          input logic signed [17:0] vals [10], input logic last);
    exp_t e;
`ifdef VSER_HEADER_EN
    e.data = 32'h8000_0000 | (last ? 32'h4000_0000 : 32'h0) | 32'(seq_num[id]);
    e.last = 1'b0;
    e.eov  = 1'b0;
    exp_q[id].push_back(e);
    seq_num[id] = (seq_num[id] + 1) % 65536;
`endif
    for (int i = 0; i < n; i++) begin
      e.data = extend(vals[i], se);
      e.last = last && (i == n - 1);
      e.eov  = (i == n - 1);
      exp_q[id].push_back(e);
    end
    vec_cnt[id]++;
  endtask

  // One cycle of checking for one DUT, evaluated between clock edges.
  task automatic check_cycle(input int id, input int n, input int depth, input bit se,
                             input logic ov, input logic [31:0] od, input logic ol,
                             input logic us, input logic ds, input logic iv,
                             input logic signed [17:0] vals [10], input logic il);
    bit   full;
    exp_t e;
    string tag;
    tag = (id == 0) ? "a" : "b";
    if (reset) begin
      exp_q[id].delete();
      vec_cnt[id] = 0;
      seq_num[id] = 0;
      return;
    end
    full = (vec_cnt[id] == depth);
    check({tag, "_out_valid"}, 32'(ov), 32'(exp_q[id].size() != 0));
    check({tag, "_upstream_stall"}, 32'(us), 32'(full));
    if (ov && exp_q[id].size() != 0) begin
      e = exp_q[id][0];
      check({tag, "_out_data"}, od, e.data);
      check({tag, "_out_last"}, 32'(ol), 32'(e.last));
      if (!ds) begin
        void'(exp_q[id].pop_front());
        if (e.eov) vec_cnt[id]--;
      end
    end
    if (iv && !full) push_vec(id, n, se, vals, il);
  endtask

  // Monitor: both DUTs are observed on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 10; i++) b_vals[i] = (i < B_N) ? b_data[i] : 18'sd0;
    check_cycle(0, A_N, A_DEPTH, 1'b1, a_ovalid, a_odata, a_olast, a_ustall, a_dstall,
                a_valid, a_data, a_last);
    check_cycle(1, B_N, B_DEPTH, 1'b0, b_ovalid, b_odata, b_olast, b_ustall, b_dstall,
                b_valid, b_vals, b_last);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic last, input int budget);
    bit done;
    done = 1'b0;
    a_valid = 1'b1;
    a_last  = last;
    for (int k = 0; k < budget && !done; k++) begin
      done = !a_ustall;
      tick();
    end
    a_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: vector not accepted within %0d cycles", budget);
    end else begin
      $display("[TB] A vector accepted, last=%0b, first value %0d", last, a_data[0]);
    end
  endtask

  task automatic fill_a(input int base);
    for (int i = 0; i < A_N; i++) a_data[i] = 18'(base + i);
  endtask

  initial begin
    logic [31:0] held;
    reset = 1'b1;
    a_valid = 0; a_last = 0; a_dstall = 0;
    b_valid = 0; b_last = 0; b_dstall = 0;
    for (int i = 0; i < A_N; i++) a_data[i] = '0;
    for (int i = 0; i < B_N; i++) b_data[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_out_valid", 32'(a_ovalid), 32'd0);
    check("reset_out_last", 32'(a_olast), 32'd0);
    check("reset_upstream_stall", 32'(a_ustall), 32'd0);

    // Values -1..-10, last tagged; word 0 visible right after the accept edge.
    for (int i = 0; i < A_N; i++) a_data[i] = 18'(-(i + 1));
    push_a(1'b1, 5);
    check("latency_valid", 32'(a_ovalid), 32'd1);
`ifdef VSER_HEADER_EN
    check("latency_word0", a_odata, 32'hC000_0000);
`else
    check("latency_word0", a_odata, 32'hFFFF_FFFF);
`endif
    repeat (15) tick();

    // Zero extension on the second instance.
    b_data[0] = 18'h3FFFF; b_valid = 1'b1; b_last = 1'b1;
    tick();
    b_valid = 1'b0;
    $display("[TB] B vector accepted, value 3ffff");
`ifdef VSER_HEADER_EN
    check("zero_ext_word0", b_odata, 32'hC000_0000);
`else
    check("zero_ext_word0", b_odata, 32'h0003_FFFF);
`endif
    repeat (5) tick();

    // Three vectors against a stalled consumer: third waits for a free slot.
    a_dstall = 1'b1;
    fill_a(100); push_a(1'b0, 5);
    fill_a(200); push_a(1'b1, 5);
    fill_a(300); a_valid = 1'b1; a_last = 1'b0;
    repeat (3) begin
      check("full_stall", 32'(a_ustall), 32'd1);
      tick();
    end
    a_dstall = 1'b0;
    push_a(1'b0, 30);
    repeat (30) tick();

    // Mid-vector consumer stall for 5 cycles.
    fill_a(-50); push_a(1'b1, 5);
    repeat (4) tick();
    a_dstall = 1'b1;
    held = a_odata;
    repeat (5) tick();
    check("stall_hold", a_odata, held);
    a_dstall = 1'b0;
    repeat (15) tick();

    // Reset mid-vector with a second vector queued.
    fill_a(1000); push_a(1'b0, 5);
    fill_a(2000); push_a(1'b1, 5);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_valid", 32'(a_ovalid), 32'd0);
    check("post_reset_ustall", 32'(a_ustall), 32'd0);
    fill_a(3000); push_a(1'b1, 5);
    repeat (15) tick();

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      a_valid = ($urandom_range(0, 9) < 7);
      a_last  = 1'($urandom_range(0, 1));
      for (int i = 0; i < A_N; i++) a_data[i] = 18'($urandom);
      a_dstall = ($urandom_range(0, 9) < 3);
      b_valid = ($urandom_range(0, 9) < 6);
      b_last  = 1'($urandom_range(0, 1));
      b_data[0] = 18'($urandom);
      b_dstall = ($urandom_range(0, 9) < 4);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 0; a_valid = 0; b_valid = 0; a_dstall = 0; b_dstall = 0;
    repeat (60) tick();
    check("drain_a", 32'(exp_q[0].size()), 32'd0);
    check("drain_b", 32'(exp_q[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_serializer.md
Name: vector_serializer

Overview:
Parametrised successor to the single-slot vector serializer. It buffers up to DEPTH complete N-channel result vectors from the model and emits them one WORD_SIZE word per cycle, with programmable sign or zero extension. out_last is registered per vector, so the `last` tag travels with its data. It sits between the model output and the DE1-SoC word streaming interface.

Parameters:
N, 10, channels per vector (>=1)
DATA_BITS, 18, bits per channel value (1..WORD_SIZE)
WORD_SIZE, 32, output word width
DEPTH, 2, vector slots in buffer (>=1, any integer, need not be power of 2)
SIGN_EXTEND, 1, 1 = sign-extend each value to WORD_SIZE; 0 = zero-extend

Ports:
clock  input  1  clock; all logic on posedge
reset  input  1  reset, synchronous, active-high
in_data  input  N x DATA_BITS signed (unpacked array)  input vector
in_valid  input  1  in_data/in_last valid
in_last  input  1  vector is final of a frame
upstream_stall  output  1  high = vector not accepted this cycle
out_data  output  WORD_SIZE  current output word
out_valid  output  1  out_data valid
out_last  output  1  final word of a last-tagged vector
downstream_stall  input  1  high = consumer not taking word

Behaviour:
- Storage: circular buffer of DEPTH slots. Each slot holds N values plus a last flag. Registers: wr_ptr, rd_ptr (0..DEPTH-1), count (0..DEPTH), word_idx (0..N-1). Counters are at least 1 bit wide.
- Accept: vector written when in_valid && !upstream_stall.
  - Slot[wr_ptr] <= {in_data, in_last}.
  - wr_ptr wraps DEPTH-1 -> 0.
- upstream_stall = (count == DEPTH). It is combinational from registered count only, with no pass-through: a full buffer stalls even if a slot frees that same cycle.
- Emit:
  - out_valid = (count != 0).
  - out_data = extend(slot[rd_ptr].value[word_idx]).
  - out_last = slot[rd_ptr].last && word_idx == N-1.
  - All outputs are driven from registers via a mux; no input-to-output combinational path.
- Transfer: a word transfers when out_valid && !downstream_stall.
  - word_idx increments.
  - At N-1: word_idx <= 0, rd_ptr advances with wrap, and the slot is freed.
- Simultaneous accept and free in one cycle: count unchanged, both pointers advance.
- Extension: if SIGN_EXTEND, replicate value MSB into bits WORD_SIZE-1..DATA_BITS; else fill with zeros. When DATA_BITS == WORD_SIZE, pass the value through unchanged.
- Latency: a vector accepted at edge k into an empty buffer gives out_valid=1 and word 0 after edge k. Throughput is 1 word/cycle while unstalled; vector-to-vector has no bubble.
- Stall hold: while downstream_stall=1, out_data, out_valid and out_last are stable.
- Reset (any time, including mid-vector): count=0, wr_ptr=rd_ptr=0, word_idx=0. Results: out_valid=0, out_last=0, upstream_stall=0, and partially emitted vectors are discarded. Slot contents are not cleared, and out_data is don't-care while out_valid=0. in_valid is ignored in the reset cycle.
- N=1: every vector is one word; out_last = slot last flag.

Optional Feature:
VSER_HEADER_EN
- Defined:
  - Each vector is preceded by one header word, and word_idx spans 0..N, where index 0 is the header.
  - Header layout: bit WORD_SIZE-1 = 1 (marker); bit WORD_SIZE-2 = slot last flag; bits 15:0 = 16-bit vector sequence number; all other bits 0.
  - The sequence number resets to 0, increments after each vector's final word transfers, and wraps 65535 -> 0.
  - out_last applies to the final data word only, never to the header.
  - Requires WORD_SIZE >= 18.
- Undefined: exactly N words per vector, no sequence counter logic.

Test Plan:
1. N=10, DEPTH=2, SIGN_EXTEND=1: push vector values -1..-10 with in_last=1, downstream_stall=0 -> 10 consecutive words 0xFFFFFFFF, 0xFFFFFFFE, ... 0xFFFFFFF6; out_last=1 only on word 10.
2. SIGN_EXTEND=0: value 18'h3FFFF -> out_data 0x0003FFFF.
3. Push 3 vectors back-to-back with downstream_stall=1 -> first two accepted, upstream_stall=1 on third until word 10 of vector A transfers. Then B and C emit with no bubble, and out_last follows each vector's own tag (A=0, B=1, C=0).
4. Assert downstream_stall mid-vector at word 4 for 5 cycles -> out_data holds value 4 unchanged, and word 5 follows on release.
5. Pulse reset after word 3 of a vector with a second vector queued -> next cycle out_valid=0, upstream_stall=0. A new vector then emits from word 0, with no stale data.
6. VSER_HEADER_EN, N=2, two vectors, second in_last=1 -> header 0x80000000, d0, d1, then header 0xC0000001, d0, d1 (out_last on the final d1).
